// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver.
// Glyph table (GFEDCBA, active-high), blank pattern, width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Entry i is the glyph for hex digit i; the first element is entry 15.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // clog2 with a floor of 1 so single-entry counters still have a bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_glyph.sv
// Hex nibble to active-high 7-segment pattern (GFEDCBA).
// Ports: nib_i nibble in, glyph_o segment pattern out.
module seg7_hex_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] glyph_o
);

  assign glyph_o = SEG_GLYPH[nib_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with guard and blanking.
// Ports: clk, reset, load/value/dp_in, enable -> seg, dp, digit_sel, pending, frame.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DIV            = 12000,
  parameter int GUARD          = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int BLANK_LEADING  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  enable,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  pending,
  output logic                  frame
);

  localparam int IW = idx_w(DIGITS);
  localparam int DW = idx_w(DIV);

  localparam logic SEG_LOW = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_LOW = (DIG_ACTIVE_LOW != 0);

  localparam logic [6:0] SEG_INACT = SEG_LOW ? 7'h7F : 7'h00;
  localparam logic DP_INACT = SEG_LOW;
  localparam logic [DIGITS-1:0] DIG_INACT =
    DIG_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [DW-1:0]         div_q, div_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   disp_val_q, disp_val_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
  logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic                  pend_q, pend_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     sel_q, sel_d;

  logic                  frame_c;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [6:0]            glyph;
  logic [DIGITS-1:0]     blank;
  logic                  hi_zero;
  logic [6:0]            seg_act;
  logic                  dp_act;
  logic [DIGITS-1:0]     sel_act;

  assign frame_c = (div_q == '0) && (idx_q == '0);

  // Held low during reset so the pulse only appears once scanning runs.
  assign frame     = frame_c & ~reset;
  assign pending   = pend_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_sel = sel_q;

  always_comb begin
    div_d = div_q + DW'(1);
    idx_d = idx_q;
    if (div_q == DW'(DIV - 1)) begin
      div_d = '0;
      if (idx_q == IW'(DIGITS - 1)) idx_d = '0;
      else                          idx_d = idx_q + IW'(1);
    end
  end

  // Display only changes on a frame cycle, so a frame never mixes values.
  always_comb begin
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_d     = pend_q;
    if (frame_c) begin
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
      end else if (pend_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
      pend_d = 1'b0;
    end else if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
      pend_d     = 1'b1;
    end
  end

  seg7_hex_glyph u_glyph (
    .nib_i   (cur_nib),
    .glyph_o (glyph)
  );

  always_comb begin
    blank   = '0;
    hi_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      hi_zero  = hi_zero & (disp_val_q[4*i +: 4] == 4'h0);
      blank[i] = hi_zero & (BLANK_LEADING != 0);
    end
  end

  always_comb begin
    cur_nib   = disp_val_q[4*int'(idx_q) +: 4];
    cur_dp    = disp_dp_q[int'(idx_q)];
    cur_blank = blank[int'(idx_q)];

    sel_act = '0;
    if (enable && (div_q >= DW'(GUARD)))
      sel_act[int'(idx_q)] = 1'b1;

    seg_act = (enable && !cur_blank) ? glyph : SEG_OFF;
    dp_act  = enable & cur_dp;

    seg_d = SEG_LOW ? ~seg_act : seg_act;
    dp_d  = SEG_LOW ? ~dp_act  : dp_act;
    sel_d = DIG_LOW ? ~sel_act : sel_act;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      idx_q      <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_q     <= 1'b0;
      seg_q      <= SEG_INACT;
      dp_q       <= DP_INACT;
      sel_q      <= DIG_INACT;
    end else begin
      div_q      <= div_d;
      idx_q      <= idx_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_q     <= pend_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      sel_q      <= sel_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (DIGITS=4, DIV=8, GUARD=2, active-low).
// Cycle t counts negedges since reset release; pins at t reflect state t-1.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        enable;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  digit_sel;
  logic        pending;
  logic        frame;

  int n_vec = 0;
  int n_bad = 0;
  int t = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS(4), .DIV(8), .GUARD(2),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1), .BLANK_LEADING(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .value     (value),
    .dp_in     (dp_in),
    .enable    (enable),
    .seg       (seg),
    .dp        (dp),
    .digit_sel (digit_sel),
    .pending   (pending),
    .frame     (frame)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @t=%0d: got %0h want %0h", tag, t, got, exp);
    end
  endtask

  task automatic wait_to(input int target);
    while (t < target) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic do_load(input int c, input logic [15:0] v,
                         input logic [3:0] d);
    wait_to(c);
    load  = 1'b1;
    value = v;
    dp_in = d;
    wait_to(c + 1);
    load  = 1'b0;
  endtask

  task automatic pins(input string tag, input logic [3:0] sel,
                      input logic [6:0] s, input logic d);
    check({tag, ".sel"}, 32'(digit_sel), 32'(sel));
    check({tag, ".seg"}, 32'(seg), 32'(s));
    check({tag, ".dp"}, 32'(dp), 32'(d));
  endtask

  initial begin
    reset  = 1'b1;
    load   = 1'b0;
    value  = '0;
    dp_in  = '0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    pins("rst", 4'hF, 7'h7F, 1'b1);
    check("rst.frame", 32'(frame), 0);
    @(negedge clk);
    reset = 1'b0;
    t = 0;
    #1;
    pins("t0", 4'hF, 7'h7F, 1'b1);
    check("t0.pend", 32'(pending), 0);
    check("t0.frame", 32'(frame), 1);

    wait_to(1);
    check("t1.frame", 32'(frame), 0);
    pins("t1", 4'hF, 7'h40, 1'b1);
    wait_to(2);
    check("t2.sel", 32'(digit_sel), 32'h0F);
    wait_to(3);
    pins("t3", 4'hE, 7'h40, 1'b1);
    wait_to(8);
    pins("t8", 4'hE, 7'h40, 1'b1);
    wait_to(9);
    pins("t9", 4'hF, 7'h7F, 1'b1);

    do_load(12, 16'h1A2F, 4'b0100);
    check("ld1.pend", 32'(pending), 1);
    wait_to(32);
    check("f32.frame", 32'(frame), 1);
    check("f32.pend", 32'(pending), 1);
    wait_to(33);
    check("f33.pend", 32'(pending), 0);
    check("f33.frame", 32'(frame), 0);
    wait_to(36);
    pins("d0F", 4'hE, 7'h0E, 1'b1);
    wait_to(44);
    pins("d1_2", 4'hD, 7'h24, 1'b1);
    wait_to(52);
    pins("d2_A", 4'hB, 7'h08, 1'b0);
    wait_to(60);
    pins("d3_1", 4'h7, 7'h79, 1'b1);

    do_load(66, 16'h0005, 4'b0000);
    wait_to(100);
    pins("z0_5", 4'hE, 7'h12, 1'b1);
    wait_to(108);
    pins("z1blk", 4'hD, 7'h7F, 1'b1);
    wait_to(116);
    pins("z2blk", 4'hB, 7'h7F, 1'b1);
    wait_to(124);
    pins("z3blk", 4'h7, 7'h7F, 1'b1);
    do_load(126, 16'h0000, 4'b0000);
    wait_to(132);
    pins("zz0", 4'hE, 7'h40, 1'b1);

    do_load(140, 16'h1111, 4'b0000);
    do_load(145, 16'h2222, 4'b0000);
    check("ow.pend", 32'(pending), 1);
    wait_to(161);
    check("ow.clr", 32'(pending), 0);
    wait_to(164);
    pins("ow2", 4'hE, 7'h24, 1'b1);
    wait_to(192);
    check("byp.frame", 32'(frame), 1);
    do_load(192, 16'h3333, 4'b0000);
    check("byp.pend", 32'(pending), 0);
    wait_to(196);
    pins("byp3", 4'hE, 7'h30, 1'b1);
    wait_to(204);
    pins("byp3d1", 4'hD, 7'h30, 1'b1);

    wait_to(210);
    enable = 1'b0;
    wait_to(211);
    pins("en0a", 4'hF, 7'h7F, 1'b1);
    wait_to(220);
    pins("en0b", 4'hF, 7'h7F, 1'b1);
    wait_to(224);
    check("en0.frame", 32'(frame), 1);
    wait_to(230);
    enable = 1'b1;
    wait_to(231);
    pins("en1", 4'hE, 7'h30, 1'b1);

    do_load(240, 16'h4444, 4'b1111);
    check("rs.pend", 32'(pending), 1);
    wait_to(245);
    pins("rs.pre", 4'hB, 7'h30, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    pins("rs.async", 4'hF, 7'h7F, 1'b1);
    check("rs.pend0", 32'(pending), 0);
    check("rs.frame0", 32'(frame), 0);
    @(negedge clk);
    reset = 1'b0;
    t = 0;
    wait_to(3);
    pins("rs.d0", 4'hE, 7'h40, 1'b1);
    wait_to(12);
    pins("rs.d1", 4'hD, 7'h7F, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a multi-digit common-anode/cathode 7-segment display.
- Latches a packed hex value plus per-digit decimal points and scans one digit at a time.
- Digit select and segment lines are registered, with a configurable ghosting guard interval and optional leading-zero blanking.
- Generalised successor to the single-digit combinational decoder; sits between a counter/datapath and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8); digit 0 is least significant
DIV, 12000, clock cycles per digit slot (>= GUARD+2)
GUARD, 2, cycles at the start of each slot with all digit selects inactive (anti-ghosting)
SEG_ACTIVE_LOW, 1, 1 = seg/dp pins are active-low
DIG_ACTIVE_LOW, 1, 1 = digit_sel pins are active-low
BLANK_LEADING, 1, 1 = blank leading zero digits

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
load  input  1  single-cycle strobe; captures value/dp_in
value  input  4*DIGITS  packed nibbles; nibble i drives digit i
dp_in  input  DIGITS  decimal point per digit, 1 = lit
enable  input  1  0 = all outputs forced inactive; scanning continues
seg  output  7  segments {G,F,E,D,C,B,A}, polarity per SEG_ACTIVE_LOW
dp  output  1  decimal point, polarity per SEG_ACTIVE_LOW
digit_sel  output  DIGITS  one-hot digit enable, polarity per DIG_ACTIVE_LOW
pending  output  1  1 = loaded value waiting for frame boundary
frame  output  1  one-cycle pulse when scan wraps digit DIGITS-1 -> 0

Behaviour:
- Reset is asynchronous and active-high. Reset state:
  - divider = 0, scan index = 0.
  - Display and pending registers = 0; pending = 0; frame = 0.
  - seg, dp and digit_sel at their inactive level (all-ones when active-low).
  - Reset asserted mid-scan aborts immediately to this state.
- Divider counts 0..DIV-1 and wraps. When it wraps, the scan index increments, wrapping DIGITS-1 -> 0.
- frame:
  - Pulses for exactly the cycle in which divider = 0 and index = 0, i.e. the first cycle after the wrap.
  - Also pulses at the first cycle after reset release.
- Load handshake:
  - load = 1 captures value/dp_in into the pending register and sets pending = 1.
  - At the next frame cycle, pending is copied into the display register and pending clears. This avoids mid-frame tearing.
  - load during a frame cycle bypasses: the new data enters the display register directly; pending stays 0.
  - load while pending = 1 overwrites the pending data (last write wins).
- Outputs are registered; one cycle of latency from divider/index state to the pins:
  - digit_sel: active only for the current index, and only when divider >= GUARD (as seen one cycle earlier).
  - seg: hex decode of the current display nibble (standard 0-9, A-F glyphs, active-high pattern); inverted if SEG_ACTIVE_LOW.
  - dp: display dp bit of the current digit.
- Leading-zero blanking (BLANK_LEADING = 1):
  - Digit i > 0 is blanked when its nibble and every higher nibble are 0. Digit 0 is never blanked.
  - A blanked digit shows seg inactive, but dp is still driven from dp_in and digit_sel still scans.
- enable = 0: seg, dp and digit_sel are forced inactive from the next cycle. Divider, index, frame and load logic are unaffected.
- DIGITS = 1: index is constant 0 and frame pulses every DIV cycles.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_GLYPH: 16-entry constant of 7-bit active-high patterns, GFEDCBA order.
  - SEG_OFF = 7'b0000000.
  - Width helper constant for the index, clog2(DIGITS) with a minimum of 1.
- One natural combinational sub-module, seg7_hex_glyph: nibble in, 7-bit active-high pattern out, using SEG_GLYPH.
- Polarity inversion is applied only in the output register stage of seg7_scan_driver.

Test Plan:
Bench configuration: DIGITS=4, DIV=8, GUARD=2, both polarities active-low, BLANK_LEADING=1.
1. Reset release -> seg=7'h7F, digit_sel=4'hF, pending=0, frame=1 in the first cycle after release. Then digit 0 is selected (digit_sel=4'hE) from cycle 3 to cycle 8 of the slot, showing seg=~7'h3F.
2. load with value=16'h1A2F, dp_in=4'b0100, issued mid-frame -> pending=1 until the next frame pulse, then 0. Over the following frame: digit0 seg=~7'h71, digit1 ~7'h5B, digit2 ~7'h77 with dp=0 (lit), digit3 ~7'h06.
3. load 16'h0005 -> digits 3..1 show seg=7'h7F while digit_sel still scans; digit 0 shows ~7'h6D. Then load 16'h0000 -> digit 0 shows ~7'h3F.
4. Two loads (16'h1111, then 16'h2222) before the frame boundary; then a load coinciding with the frame pulse -> display shows 2222 and pending clears; the coinciding load appears in the same frame with pending staying 0.
5. enable=0 for 20 cycles -> all pins inactive, frame still pulses every 32 cycles; re-enable -> scanning resumes at the current index.
6. Assert reset at divider=5, index=2 -> outputs inactive asynchronously, pending cleared; the display register shows 0 after release.
